// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared encodings for the PC sequencer and the PC datapath.
//   - FSM state encoding (also visible on state_out for debug)
//   - decoded instruction class codes driven into inst_class
//   - pc_mux_sel codes understood by the PC datapath
//   - mem_src_sel codes understood by the memory address mux
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_TRAPV  = 3'd5
  } state_t;

  localparam logic [2:0] CLS_ALU     = 3'd0;
  localparam logic [2:0] CLS_JAL     = 3'd1;
  localparam logic [2:0] CLS_JALR    = 3'd2;
  localparam logic [2:0] CLS_BRANCH  = 3'd3;
  localparam logic [2:0] CLS_LOAD    = 3'd4;
  localparam logic [2:0] CLS_STORE   = 3'd5;
  localparam logic [2:0] CLS_MRET    = 3'd6;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  localparam logic [2:0] PC_HOLD     = 3'd0;
  localparam logic [2:0] PC_PLUS4    = 3'd1;
  localparam logic [2:0] PC_JAL      = 3'd2;
  localparam logic [2:0] PC_JALR     = 3'd3;
  localparam logic [2:0] PC_BRANCH   = 3'd4;
  localparam logic [2:0] PC_MEPC     = 3'd5;
  localparam logic [2:0] PC_MEM_DOUT = 3'd6;

  localparam logic [1:0] SRC_PC      = 2'd0;
  localparam logic [1:0] SRC_ALU     = 2'd1;
  localparam logic [1:0] SRC_TRAPVEC = 2'd2;

endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control FSM for the program counter datapath.
// Walks each instruction through FETCH, DECODE, EXEC and an optional MEM
// phase, owns the single memory port handshake, takes traps/interrupts at
// instruction boundaries (including the trap-vector fetch) and counts
// retired instructions.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   inst_class   decoded class of the instruction register
//   irq          level interrupt request (sampled only in DECODE)
//   mem_ack      memory transfer complete / read data valid
//   mem_req      memory transfer request
//   mem_we       write strobe, qualified by mem_req
//   mem_src_sel  memory address source (pc_out, alu_out, trap vector)
//   ir_load      latch mem_dout into the instruction register
//   rd_we        register-file write enable
//   pc_mux_sel   PC update select
//   trap_enter   one-cycle pulse: save mepc/mcause
//   trap_cause   0 exception, 1 interrupt (qualified by trap_enter)
//   state_out    current FSM state
//   instret      retired-instruction count (wraps)
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC_ADDR = 32'h0000_0000,
  parameter int          CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       inst_class,
  input  logic             irq,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_src_sel,
  output logic             ir_load,
  output logic             rd_we,
  output logic [2:0]       pc_mux_sel,
  output logic             trap_enter,
  output logic             trap_cause,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] instret
);

  // The trap vector is fetched as a whole word, so it must be word aligned.
  if (TRAP_VEC_ADDR[1:0] != 2'b00) begin : g_trap_vec_misaligned
    $error("TRAP_VEC_ADDR must be word aligned");
  end

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] instret_reg;
  logic             retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_src_sel = SRC_PC;
    ir_load     = 1'b0;
    rd_we       = 1'b0;
    pc_mux_sel  = PC_HOLD;
    trap_enter  = 1'b0;
    trap_cause  = 1'b0;
    retire      = 1'b0;

    case (state_reg)
      // One idle cycle lets the PC's own reset settle before the first fetch.
      ST_IDLE: begin
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        mem_req     = 1'b1;
        mem_src_sel = SRC_PC;
        if (mem_ack) begin
          ir_load    = 1'b1;
          state_next = ST_DECODE;
        end
      end

      // Interrupts are only taken here, so an instruction is never split.
      ST_DECODE: begin
        if (irq) begin
          trap_enter = 1'b1;
          trap_cause = 1'b1;
          state_next = ST_TRAPV;
        end else if (inst_class == CLS_ILLEGAL) begin
          trap_enter = 1'b1;
          trap_cause = 1'b0;
          state_next = ST_TRAPV;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_next = ST_FETCH;
        case (inst_class)
          CLS_ALU: begin
            pc_mux_sel = PC_PLUS4;
            rd_we      = 1'b1;
            retire     = 1'b1;
          end
          CLS_JAL: begin
            pc_mux_sel = PC_JAL;
            rd_we      = 1'b1;
            retire     = 1'b1;
          end
          CLS_JALR: begin
            pc_mux_sel = PC_JALR;
            rd_we      = 1'b1;
            retire     = 1'b1;
          end
          CLS_BRANCH: begin
            pc_mux_sel = PC_BRANCH;
            retire     = 1'b1;
          end
          CLS_MRET: begin
            pc_mux_sel = PC_MEPC;
            retire     = 1'b1;
          end
          CLS_LOAD, CLS_STORE: begin
            state_next = ST_MEM;
          end
          default: begin
            // An illegal class here can only come from a changed IR;
            // route back through DECODE so it traps rather than retires.
            state_next = ST_DECODE;
          end
        endcase
      end

      // inst_class comes from the IR, which is stable here, so mem_we
      // holds steady for the whole request.
      ST_MEM: begin
        mem_req     = 1'b1;
        mem_src_sel = SRC_ALU;
        mem_we      = (inst_class == CLS_STORE);
        if (mem_ack) begin
          pc_mux_sel = PC_PLUS4;
          rd_we      = (inst_class == CLS_LOAD);
          retire     = 1'b1;
          state_next = ST_FETCH;
        end
      end

      // Fetch the handler entry PC; the trapped instruction does not retire.
      ST_TRAPV: begin
        mem_req     = 1'b1;
        mem_src_sel = SRC_TRAPVEC;
        if (mem_ack) begin
          pc_mux_sel = PC_MEM_DOUT;
          state_next = ST_FETCH;
        end
      end

      // Unused encodings recover on the next clock with all outputs idle.
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign state_out = state_reg;
  assign instret   = instret_reg;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control FSM that drives the program-counter datapath's pc_mux_sel (0 hold, 1 pc+4, 2 pc+imm_j, 3 alu_out&~1, 4 branch, 5 mepc, 6 mem_dout).
Sequences each instruction through fetch, decode, execute and optional memory phases, and owns the single memory port handshake.
Takes traps and interrupts at instruction boundaries, including the trap-vector fetch.
Counts retired instructions.

Parameters:
TRAP_VEC_ADDR, 32'h0000_0000, address of the memory word holding the trap-handler entry PC
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
inst_class  input  3  decoded class of the instruction register: 0 ALU, 1 JAL, 2 JALR, 3 BRANCH, 4 LOAD, 5 STORE, 6 MRET, 7 ILLEGAL/ECALL
irq  input  1  level interrupt request
mem_ack  input  1  memory transfer complete; read data valid on mem_dout this cycle
mem_req  output  1  memory transfer request
mem_we  output  1  write strobe, qualified by mem_req
mem_src_sel  output  2  memory address source: 0 pc_out, 1 alu_out, 2 TRAP_VEC_ADDR
ir_load  output  1  latch mem_dout into the instruction register
rd_we  output  1  register-file write enable
pc_mux_sel  output  3  PC update select (codes above)
trap_enter  output  1  one-cycle pulse; CSR block saves mepc <= pc_out and mcause
trap_cause  output  1  qualified by trap_enter: 0 exception, 1 interrupt
state_out  output  3  current FSM state, for debug
instret  output  CNT_W  retired-instruction count

Behaviour:
- Registers are state and instret only. All other outputs are combinational from state, inst_class, irq and mem_ack.
- Reset (reset==0): asynchronous. state=IDLE, instret=0.
  - Every output is 0 immediately, including pc_mux_sel=0.
  - Any in-flight memory transfer is abandoned; a late mem_ack is ignored.
- IDLE: all outputs 0. Next state is unconditionally FETCH. This gives one cycle for the PC's synchronous reset to settle.
- FETCH: mem_req=1, mem_src_sel=0, pc_mux_sel=0.
  - mem_ack=0: stay.
  - mem_ack=1: ir_load=1, go to DECODE.
- DECODE: pc_mux_sel=0.
  - irq=1: trap_enter=1, trap_cause=1, go to TRAPV. irq has priority over class 7.
  - else inst_class=7: trap_enter=1, trap_cause=0, go to TRAPV.
  - else: go to EXEC.
  - irq is sampled only in DECODE. An interrupt therefore never splits an instruction.
- EXEC: one cycle for non-memory classes. Sets pc_mux_sel, rd_we, increments instret, then goes to FETCH:
  - ALU: pc_mux_sel=1, rd_we=1.
  - JAL: pc_mux_sel=2, rd_we=1.
  - JALR: pc_mux_sel=3, rd_we=1.
  - BRANCH: pc_mux_sel=4, rd_we=0. take_branch is resolved inside the PC datapath.
  - MRET: pc_mux_sel=5, rd_we=0.
  - LOAD/STORE: pc_mux_sel=0, go to MEM, no increment.
- MEM: mem_req=1, mem_src_sel=1, mem_we=(inst_class==STORE).
  - mem_ack=0: stay, pc_mux_sel=0.
  - mem_ack=1: pc_mux_sel=1, rd_we=(LOAD), instret+1, go to FETCH.
- TRAPV: mem_req=1, mem_src_sel=2, mem_we=0.
  - mem_ack=0: pc_mux_sel=0.
  - mem_ack=1: pc_mux_sel=6, go to FETCH. instret is not incremented for trapped instructions.
- Handshake rules:
  - While mem_req=1, mem_src_sel and mem_we are stable and mem_req stays high until mem_ack.
  - mem_ack while mem_req=0 is ignored.
  - Ack in the first request cycle is legal, giving 0-wait-state operation.
- Cycle counts with 0-wait-state memory:
  - ALU/JAL/JALR/BRANCH/MRET: 3 cycles.
  - LOAD/STORE: 4 cycles.
  - Trap entry from FETCH to handler FETCH: 3 cycles.
- instret wraps modulo 2^CNT_W with no flag.
- pc_mux_sel is never 7. State encodings 6 and 7 are unused and recover to IDLE on the next clock.

Decomposition:
- Shared package pc_seq_pkg holds:
  - State encoding constants: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, TRAPV=5.
  - inst_class codes.
  - pc_mux_sel codes 0..6, shared with the PC datapath.
  - mem_src_sel codes.
- Single module; no sub-module is warranted (the counter is a few lines).

Test Plan:
- Reset release with mem_ack tied 1 and an ALU stream: state IDLE->FETCH->DECODE->EXEC repeats. pc_mux_sel=1 only in EXEC. instret=3 after 9 cycles following IDLE.
- LOAD with 2 wait states (ack on the 3rd MEM cycle): mem_src_sel=1, mem_we=0 for 3 cycles. Then rd_we=1 and pc_mux_sel=1 in the ack cycle; instret+1. A STORE gives mem_we=1 and rd_we=0.
- irq=1 during FETCH of an ALU instruction: trap_enter=1, trap_cause=1 in DECODE. TRAPV asserts mem_src_sel=2; on ack pc_mux_sel=6. instret unchanged; no rd_we.
- inst_class=7 with irq=0: trap_cause=0. With irq=1 and class 7 together: trap_cause=1.
- JAL/JALR/BRANCH/MRET in EXEC: pc_mux_sel=2/3/4/5, rd_we=1/1/0/0.
- Reset asserted mid-MEM while mem_req=1: mem_req falls in the same cycle, state_out=0, instret=0. A subsequent mem_ack is ignored. FETCH resumes one cycle after release.
